// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared widths, opcode/funct3 constants and types for alu_exec
package alu_exec_pkg;

  localparam int ROB_POS_WID = 4;
  localparam int DATA_WID    = 32;
  localparam int ADDR_WID    = 32;
  localparam int OPCODE_WID  = 7;
  localparam int FUNCT3_WID  = 3;

  localparam logic [OPCODE_WID-1:0] OPCODE_OP    = 7'b0110011;
  localparam logic [OPCODE_WID-1:0] OPCODE_OPIMM = 7'b0010011;
  localparam logic [OPCODE_WID-1:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [OPCODE_WID-1:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [OPCODE_WID-1:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [OPCODE_WID-1:0] OPCODE_JALR  = 7'b1100111;
  localparam logic [OPCODE_WID-1:0] OPCODE_BR    = 7'b1100011;

  localparam logic [FUNCT3_WID-1:0] FUNCT3_ADD  = 3'b000;
  localparam logic [FUNCT3_WID-1:0] FUNCT3_SLL  = 3'b001;
  localparam logic [FUNCT3_WID-1:0] FUNCT3_SLT  = 3'b010;
  localparam logic [FUNCT3_WID-1:0] FUNCT3_SLTU = 3'b011;
  localparam logic [FUNCT3_WID-1:0] FUNCT3_XOR  = 3'b100;
  localparam logic [FUNCT3_WID-1:0] FUNCT3_SR   = 3'b101;
  localparam logic [FUNCT3_WID-1:0] FUNCT3_OR   = 3'b110;
  localparam logic [FUNCT3_WID-1:0] FUNCT3_AND  = 3'b111;

  localparam logic [FUNCT3_WID-1:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [FUNCT3_WID-1:0] FUNCT3_BNE  = 3'b001;
  localparam logic [FUNCT3_WID-1:0] FUNCT3_BLT  = 3'b100;
  localparam logic [FUNCT3_WID-1:0] FUNCT3_BGE  = 3'b101;
  localparam logic [FUNCT3_WID-1:0] FUNCT3_BLTU = 3'b110;
  localparam logic [FUNCT3_WID-1:0] FUNCT3_BGEU = 3'b111;

  typedef struct packed {
    logic [OPCODE_WID-1:0]  opcode;
    logic [FUNCT3_WID-1:0]  funct3;
    logic                   funct7;
    logic [DATA_WID-1:0]    val1;
    logic [DATA_WID-1:0]    val2;
    logic [DATA_WID-1:0]    imm;
    logic [ADDR_WID-1:0]    pc;
    logic [ROB_POS_WID-1:0] rob_pos;
  } issue_t;

  function automatic logic branch_taken(input logic [FUNCT3_WID-1:0] funct3,
                                        input logic [DATA_WID-1:0] a,
                                        input logic [DATA_WID-1:0] b);
    logic taken;
    case (funct3)
      FUNCT3_BEQ:  taken = (a == b);
      FUNCT3_BNE:  taken = (a != b);
      FUNCT3_BLT:  taken = ($signed(a) < $signed(b));
      FUNCT3_BGE:  taken = ($signed(a) >= $signed(b));
      FUNCT3_BLTU: taken = (a < b);
      FUNCT3_BGEU: taken = (a >= b);
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_exec_core.sv
// rtl/alu_exec_core.sv - combinational RV32I ALU/branch/jump evaluation
module alu_exec_core
  import alu_exec_pkg::*;
(
  input  logic [OPCODE_WID-1:0] opcode,
  input  logic [FUNCT3_WID-1:0] funct3,
  input  logic                  funct7,
  input  logic [DATA_WID-1:0]   val1,
  input  logic [DATA_WID-1:0]   val2,
  input  logic [DATA_WID-1:0]   imm,
  input  logic [ADDR_WID-1:0]   pc,
  output logic [DATA_WID-1:0]   val,
  output logic [ADDR_WID-1:0]   next_pc,
  output logic                  jump
);

  logic                is_op;
  logic [DATA_WID-1:0] op2;
  logic [4:0]          shamt;
  logic [DATA_WID-1:0] alu_out;
  logic [ADDR_WID-1:0] pc_plus4;

  always_comb begin
    is_op = (opcode == OPCODE_OP);
    op2   = is_op ? val2 : imm;
    shamt = op2[4:0];

    // funct7 only picks SUB for register-register; OP-IMM ADDI ignores it
    case (funct3)
      FUNCT3_ADD:  alu_out = (is_op && funct7) ? (val1 - op2) : (val1 + op2);
      FUNCT3_SLL:  alu_out = val1 << shamt;
      FUNCT3_SLT:  alu_out = {31'd0, $signed(val1) < $signed(op2)};
      FUNCT3_SLTU: alu_out = {31'd0, val1 < op2};
      FUNCT3_XOR:  alu_out = val1 ^ op2;
      FUNCT3_SR: begin
        if (funct7) alu_out = $signed(val1) >>> shamt;
        else        alu_out = val1 >> shamt;
      end
      FUNCT3_OR:   alu_out = val1 | op2;
      default:     alu_out = val1 & op2;
    endcase

    pc_plus4 = pc + 32'd4;
    val      = '0;
    next_pc  = pc_plus4;
    case (opcode)
      OPCODE_OP, OPCODE_OPIMM: val = alu_out;
      OPCODE_LUI:              val = imm;
      OPCODE_AUIPC:            val = pc + imm;
      OPCODE_JAL: begin
        val     = pc_plus4;
        next_pc = pc + imm;
      end
      OPCODE_JALR: begin
        val     = pc_plus4;
        next_pc = (val1 + imm) & ~32'd1;
      end
      OPCODE_BR: begin
        if (branch_taken(funct3, val1, val2)) next_pc = pc + imm;
      end
      default: ;
    endcase
    jump = (next_pc != pc_plus4);
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - RV32I integer execute stage; ALU_EXEC_PIPE2_EN adds a second register stage
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   alu_en,
  input  logic [OPCODE_WID-1:0]  alu_opcode,
  input  logic [FUNCT3_WID-1:0]  alu_funct3,
  input  logic                   alu_funct7,
  input  logic [DATA_WID-1:0]    alu_val1,
  input  logic [DATA_WID-1:0]    alu_val2,
  input  logic [DATA_WID-1:0]    alu_imm,
  input  logic [ADDR_WID-1:0]    alu_pc,
  input  logic [ROB_POS_WID-1:0] alu_rob_pos,
  output logic                   alu_result,
  output logic [ROB_POS_WID-1:0] alu_result_rob_pos,
  output logic [DATA_WID-1:0]    alu_result_val,
  output logic                   alu_result_jump,
  output logic [ADDR_WID-1:0]    alu_result_pc
);

  issue_t              issue_in;
  issue_t              core_in;
  logic                core_en;
  logic [DATA_WID-1:0] core_val;
  logic [ADDR_WID-1:0] core_next_pc;
  logic                core_jump;

  assign issue_in = '{opcode: alu_opcode, funct3: alu_funct3, funct7: alu_funct7,
                      val1: alu_val1, val2: alu_val2, imm: alu_imm,
                      pc: alu_pc, rob_pos: alu_rob_pos};

`ifdef ALU_EXEC_PIPE2_EN
  logic   s1_valid;
  issue_t s1_issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_issue <= '0;
    end else if (rollback) begin
      s1_valid <= 1'b0;
    end else if (rdy) begin
      s1_valid <= alu_en;
      if (alu_en) s1_issue <= issue_in;
    end
  end

  assign core_en = s1_valid;
  assign core_in = s1_issue;
`else
  assign core_en = alu_en;
  assign core_in = issue_in;
`endif

  alu_exec_core u_core (
    .opcode  (core_in.opcode),
    .funct3  (core_in.funct3),
    .funct7  (core_in.funct7),
    .val1    (core_in.val1),
    .val2    (core_in.val2),
    .imm     (core_in.imm),
    .pc      (core_in.pc),
    .val     (core_val),
    .next_pc (core_next_pc),
    .jump    (core_jump)
  );

  // payload only loads with a valid instruction so it holds between broadcasts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result         <= 1'b0;
      alu_result_rob_pos <= '0;
      alu_result_val     <= '0;
      alu_result_jump    <= 1'b0;
      alu_result_pc      <= '0;
    end else if (rollback) begin
      alu_result <= 1'b0;
    end else if (rdy) begin
      alu_result <= core_en;
      if (core_en) begin
        alu_result_rob_pos <= core_in.rob_pos;
        alu_result_val     <= core_val;
        alu_result_jump    <= core_jump;
        alu_result_pc      <= core_next_pc;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard bench for alu_exec with random stimulus and reference model
module tb_alu_exec;

`ifdef ALU_EXEC_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] val;
    logic [31:0] pc;
    logic        jump;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        rollback = 1'b0;
  logic        alu_en = 1'b0;
  logic [6:0]  alu_opcode = '0;
  logic [2:0]  alu_funct3 = '0;
  logic        alu_funct7 = 1'b0;
  logic [31:0] alu_val1 = '0, alu_val2 = '0, alu_imm = '0, alu_pc = '0;
  logic [3:0]  alu_rob_pos = '0;
  logic        alu_result;
  logic [3:0]  alu_result_rob_pos;
  logic [31:0] alu_result_val;
  logic        alu_result_jump;
  logic [31:0] alu_result_pc;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  exp_t held;
  logic m_v[LAT];
  exp_t m_it[LAT];
  logic fresh = 1'b0;

  always #5 clk = ~clk;

  alu_exec dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
    .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_rob_pos(alu_rob_pos), .alu_result(alu_result),
    .alu_result_rob_pos(alu_result_rob_pos), .alu_result_val(alu_result_val),
    .alu_result_jump(alu_result_jump), .alu_result_pc(alu_result_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: RV32I semantics written directly from the ISA rules.
  function automatic exp_t ref_exec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                    input logic [31:0] a, input logic [31:0] r2,
                                    input logic [31:0] imm, input logic [31:0] pc,
                                    input logic [3:0] rob);
    exp_t e;
    logic [31:0] b;
    logic [63:0] ext;
    int sh;
    logic take;
    e.rob = rob; e.val = 0; e.pc = pc + 4;
    b = (op == 7'h33) ? r2 : imm;
    sh = int'(b % 32);
    if (op == 7'h33 || op == 7'h13) begin
      case (f3)
        0: e.val = (op == 7'h33 && f7) ? a + (~b + 1) : a + b;
        1: e.val = a << sh;
        2: e.val = (int'(a) < int'(b)) ? 1 : 0;
        3: e.val = (longint'({32'd0, a}) < longint'({32'd0, b})) ? 1 : 0;
        4: e.val = a ^ b;
        5: begin
          ext = f7 ? {{32{a[31]}}, a} : {32'd0, a};
          ext = ext >> sh;
          e.val = ext[31:0];
        end
        6: e.val = a | b;
        default: e.val = a & b;
      endcase
    end else if (op == 7'h37) e.val = imm;
    else if (op == 7'h17) e.val = pc + imm;
    else if (op == 7'h6f) begin e.val = pc + 4; e.pc = pc + imm; end
    else if (op == 7'h67) begin e.val = pc + 4; e.pc = (a + imm) & 32'hFFFF_FFFE; end
    else if (op == 7'h63) begin
      case (f3)
        0: take = (a == r2);
        1: take = (a != r2);
        4: take = int'(a) < int'(r2);
        5: take = int'(a) >= int'(r2);
        6: take = longint'({32'd0, a}) < longint'({32'd0, r2});
        7: take = longint'({32'd0, a}) >= longint'({32'd0, r2});
        default: take = 1'b0;
      endcase
      if (take) e.pc = pc + imm;
    end
    e.jump = (e.pc != pc + 4);
    return e;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < LAT; k++) m_v[k] = 1'b0;
    sb_q.delete();
    fresh = 1'b0;
  endtask

  // Drive one cycle; the model advances at the edge using what was driven.
  task automatic cyc(input logic en, input logic rd, input logic rb,
                     input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                     input logic [31:0] pc, input logic [3:0] rob);
    alu_en = en; rdy = rd; rollback = rb;
    alu_opcode = op; alu_funct3 = f3; alu_funct7 = f7;
    alu_val1 = v1; alu_val2 = v2; alu_imm = imm; alu_pc = pc; alu_rob_pos = rob;
    @(posedge clk);
    fresh = 1'b0;
    if (rb) begin
      for (int k = 0; k < LAT; k++) m_v[k] = 1'b0;
    end else if (rd) begin
      for (int k = LAT - 1; k > 0; k--) begin m_v[k] = m_v[k-1]; m_it[k] = m_it[k-1]; end
      m_v[0] = en;
      if (en) m_it[0] = ref_exec(op, f3, f7, v1, v2, imm, pc, rob);
      if (m_v[LAT-1]) sb_q.push_back(m_it[LAT-1]);
      fresh = 1'b1;
    end
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [3:0] rob);
    cyc(1'b1, 1'b1, 1'b0, op, f3, f7, v1, v2, imm, pc, rob);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0, 7'h0, 3'h0, 1'b0, 0, 0, 0, 0, 4'h0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", {31'd0, alu_result}, {31'd0, m_v[LAT-1]});
      if (alu_result && m_v[LAT-1]) begin
        if (fresh) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_empty actual=broadcast required=none at %0t", $time);
          end else held = sb_q.pop_front();
        end
        chk("rob_pos", {28'd0, alu_result_rob_pos}, {28'd0, held.rob});
        chk("val", alu_result_val, held.val);
        chk("next_pc", alu_result_pc, held.pc);
        chk("jump", {31'd0, alu_result_jump}, {31'd0, held.jump});
      end
    end
  end

  logic [6:0] ops[8] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h0b};

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, alu_result}, 0);
    chk("rst_rob", {28'd0, alu_result_rob_pos}, 0);
    chk("rst_val", alu_result_val, 0);
    chk("rst_pc", alu_result_pc, 0);
    chk("rst_jump", {31'd0, alu_result_jump}, 0);
    rst = 1'b0;

    issue(7'h33, 3'd0, 1'b0, 5, 7, 0, 32'h10, 4'd3);
    issue(7'h33, 3'd0, 1'b1, 5, 7, 0, 32'h14, 4'd4);
    issue(7'h13, 3'd0, 1'b1, 1, 0, 32'h400, 32'h18, 4'd5);
    issue(7'h13, 3'd5, 1'b1, 32'h8000_0000, 0, 4, 32'h1c, 4'd6);
    issue(7'h63, 3'd4, 1'b0, 32'hFFFF_FFFF, 0, 32'h20, 32'h100, 4'd7);
    issue(7'h63, 3'd6, 1'b0, 32'hFFFF_FFFF, 0, 32'h20, 32'h100, 4'd8);
    issue(7'h67, 3'd0, 1'b0, 32'h1001, 0, 2, 32'h40, 4'd9);
    idle(3);

    // rollback with the second instruction, held through the third
    issue(7'h33, 3'd0, 1'b0, 1, 2, 0, 32'h200, 4'd1);
    cyc(1'b1, 1'b1, 1'b1, 7'h33, 3'd0, 1'b0, 3, 4, 0, 32'h204, 4'd2);
    cyc(1'b1, 1'b1, 1'b1, 7'h33, 3'd0, 1'b0, 5, 6, 0, 32'h208, 4'd3);
    idle(3);

    // stall while a broadcast is showing; alu_en must be ignored
    issue(7'h6f, 3'd0, 1'b0, 0, 0, 32'h80, 32'h300, 4'd10);
    idle(LAT - 1);
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 1'b0, 1'b0, 7'h33, 3'd0, 1'b0, 9, 9, 0, 32'h400, 4'd11);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 7)];
      if (op == 7'h0b) op = 7'($urandom);
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
          op, 3'($urandom), 1'($urandom), $urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
          $urandom, $urandom & 32'hFFFF_FFFC, 4'($urandom));
    end
    idle(3);

    // asynchronous reset in the middle of a broadcast cycle
    issue(7'h37, 3'd0, 1'b0, 0, 0, 32'h1234_5000, 32'h500, 4'd12);
    idle(LAT - 1);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("async_rst_valid", {31'd0, alu_result}, 0);
    chk("async_rst_val", alu_result_val, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
